// File: rtl/leglite_multicycle.sv
// leglite_multicycle: multicycle LEGLite core with ready-handshaked fetch and data ports.
// Define LEGLITE_PERF_CNT_EN to add the cycle_count / instr_count performance counters.
module leglite_multicycle #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] iaddr,
    output logic                  iread,
    input  logic [15:0]           idata,
    input  logic                  iready,
    output logic [ADDR_WIDTH-1:0] daddr,
    output logic                  dread,
    output logic                  dwrite,
    output logic [DATA_WIDTH-1:0] dwdata,
    input  logic [DATA_WIDTH-1:0] ddata,
    input  logic                  dready,
    output logic [DATA_WIDTH-1:0] alu_out,
    output logic [2:0]            state_out
`ifdef LEGLITE_PERF_CNT_EN
    ,
    output logic [31:0]           cycle_count,
    output logic [31:0]           instr_count
`endif
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_ORR  = 3'd3;
    localparam logic [2:0] OP_LDUR = 3'd5;
    localparam logic [2:0] OP_STUR = 3'd6;
    localparam logic [2:0] OP_CBZ  = 3'd7;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] pc, bpc, imm_a;
    logic [15:0]           ir;
    logic [DATA_WIDTH-1:0] a, b, alu_q, mdr, alu_res, imm_d;
    logic [DATA_WIDTH-1:0] regs [8];
    logic [2:0]            op, rs1, rs2, rd, rb;
    logic signed [6:0]     imm7;
    logic                  is_mem;

    assign op     = ir[15:13];
    assign rs2    = ir[12:10];
    assign imm7   = ir[12:6];
    assign rs1    = ir[5:3];
    assign rd     = ir[2:0];
    assign imm_d  = DATA_WIDTH'(imm7);
    assign imm_a  = ADDR_WIDTH'(imm7);
    assign rb     = (op == OP_STUR || op == OP_CBZ) ? rd : rs2;
    assign is_mem = op == OP_LDUR || op == OP_STUR;

    assign alu_res = (op == OP_ADD) ? a + b :
                     (op == OP_SUB) ? a - b :
                     (op == OP_AND) ? a & b :
                     (op == OP_ORR) ? a | b : a + imm_d;

    // Strobes decode straight from the state register so an async reset drops them at once.
    assign iread     = state == FETCH;
    assign dread     = state == MEM && op == OP_LDUR;
    assign dwrite    = state == MEM && op == OP_STUR;
    assign iaddr     = pc;
    assign dwdata    = b;
    assign alu_out   = alu_q;
    assign state_out = state;

    generate
        if (ADDR_WIDTH <= DATA_WIDTH) begin : g_daddr_trunc
            assign daddr = alu_q[ADDR_WIDTH-1:0];
        end else begin : g_daddr_zext
            assign daddr = {{(ADDR_WIDTH-DATA_WIDTH){1'b0}}, alu_q};
        end
    endgenerate

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic: fetch and memory states wait on their ready inputs.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = FETCH;
            FETCH:   state_nxt = iready ? DECODE : FETCH;
            DECODE:  state_nxt = EXEC;
            EXEC:    state_nxt = (op == OP_CBZ) ? FETCH : is_mem ? MEM : WB;
            MEM:     state_nxt = !dready ? MEM : (op == OP_LDUR) ? WB : FETCH;
            WB:      state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath latches: IR/PC on fetch, operands on decode, ALU result or branch on exec, MDR on load.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc    <= '0;
            bpc   <= '0;
            ir    <= '0;
            a     <= '0;
            b     <= '0;
            alu_q <= '0;
            mdr   <= '0;
        end else begin
            case (state)
                FETCH: if (iready) begin
                    ir  <= idata;
                    bpc <= pc;
                    pc  <= pc + ADDR_WIDTH'(1);
                end
                DECODE: begin
                    a <= regs[rs1];
                    b <= regs[rb];
                end
                EXEC: if (op == OP_CBZ) begin
                    if (b == '0) pc <= bpc + imm_a;
                end else begin
                    alu_q <= alu_res;
                end
                MEM: if (dready && op == OP_LDUR) mdr <= ddata;
                default: ;
            endcase
        end
    end

    // Register file: eight general registers, written only in WB.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else if (state == WB) begin
            regs[rd] <= (op == OP_LDUR) ? mdr : alu_q;
        end
    end

`ifdef LEGLITE_PERF_CNT_EN
    logic done;

    assign done = state == WB || (state == MEM && op == OP_STUR && dready) ||
                  (state == EXEC && op == OP_CBZ);

    // Free-running cycle counter and retired-instruction counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
            if (done) instr_count <= instr_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_leglite_multicycle.sv
// tb_leglite_multicycle: directed and randomized checks of leglite_multicycle against an instruction-level model.
module tb_leglite_multicycle;
    localparam int DW = 16;
    localparam int AW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] iaddr, daddr;
    logic          iread, dread, dwrite;
    logic          iready = 1'b0;
    logic          dready = 1'b0;
    logic [15:0]   idata = '0;
    logic [DW-1:0] dwdata, alu_out;
    logic [DW-1:0] ddata = '0;
    logic [2:0]    state_out;
`ifdef LEGLITE_PERF_CNT_EN
    logic [31:0]   cycle_count, instr_count;
`endif

    leglite_multicycle #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset(reset),
        .iaddr(iaddr), .iread(iread), .idata(idata), .iready(iready),
        .daddr(daddr), .dread(dread), .dwrite(dwrite), .dwdata(dwdata),
        .ddata(ddata), .dready(dready), .alu_out(alu_out), .state_out(state_out)
`ifdef LEGLITE_PERF_CNT_EN
        , .cycle_count(cycle_count), .instr_count(instr_count)
`endif
    );

    always #5 clock = ~clock;

    logic [15:0] imem   [65536];
    logic [15:0] dmem   [65536];
    logic [15:0] m_dmem [65536];
    logic [15:0] m_r    [8];
    logic [15:0] m_pc, exp_daddr, exp_wdata, exp_alu;
    int  exp_kind;
    int  n_pass = 0, n_total = 0;
    int  cyc, cur_start, cur_base, cur_waits, fetches;
    bit  have_cur, prev_iread, rnd_mode;
    int  grant_pct, dwait, dstall;
    int  fseq[$], fstart[$];
    int  st_run, first_st_len, first_st_addr, first_st_data;
    bit  st_seen;
    int  exp_seq [17] = '{0, 1, 2, 3, 4, 5, 6, 7, 10, 8, 9, 11, 65533, 65534, 65535, 0, 1};

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [15:0] enc(input int op, input int f7, input int rs1, input int rd);
        logic [15:0] w;
        w = {op[2:0], f7[6:0], rs1[2:0], rd[2:0]};
        return w;
    endfunction

    // Instruction-set model: executes one whole instruction and records what the bus must show.
    task automatic iss(input logic [15:0] w);
        logic [2:0]  op, rs1, rs2, rd;
        logic [15:0] imm, a, b, bpc, res, addr;
        op  = w[15:13];
        rs2 = w[12:10];
        rs1 = w[5:3];
        rd  = w[2:0];
        imm = {{9{w[12]}}, w[12:6]};
        a   = m_r[rs1];
        b   = (op >= 3'd6) ? m_r[rd] : m_r[rs2];
        bpc = m_pc;
        m_pc = m_pc + 16'd1;
        addr = a + imm;
        exp_kind = 0;
        cur_base = 4;
        res = addr;
        case (op)
            3'd0: res = a + b;
            3'd1: res = a - b;
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd5: begin exp_kind = 1; cur_base = 5; exp_daddr = addr; end
            3'd6: begin exp_kind = 2; exp_daddr = addr; exp_wdata = b; m_dmem[addr] = b; end
            3'd7: begin cur_base = 3; if (b == 16'd0) m_pc = bpc + imm; end
            default: ;
        endcase
        exp_alu = res;
        if (op <= 3'd5) m_r[rd] = (op == 3'd5) ? m_dmem[addr] : res;
    endtask

    // One cycle: compare outputs with the model at the negedge, then drive the memory responses.
    task automatic tick();
        bit ig, dg;
        @(negedge clock);
        cyc++;
        chk("one_strobe", int'(iread) + int'(dread) + int'(dwrite) <= 1, 1);
        chk("state_range", state_out <= 3'd5, 1);
`ifdef LEGLITE_PERF_CNT_EN
        chk("cycle_count", cycle_count, cyc - 1);
`endif
        if (iread && !prev_iread) begin
            if (have_cur) chk("latency", cyc - cur_start, cur_base + cur_waits);
`ifdef LEGLITE_PERF_CNT_EN
            chk("instr_count", instr_count, fetches);
`endif
            fetches++;
            have_cur  = 1;
            cur_start = cyc;
            cur_waits = 0;
            fseq.push_back(int'(iaddr));
            fstart.push_back(cyc);
        end
        if (iread) chk("iaddr", iaddr, m_pc);
        if (dread || dwrite) begin
            chk("dkind", dwrite ? 2 : 1, exp_kind);
            chk("daddr", daddr, exp_daddr);
            if (dwrite) chk("dwdata", dwdata, exp_wdata);
        end
        if (state_out == 3'd4 || state_out == 3'd5) chk("alu_out", alu_out, exp_alu);
        if (dwrite && !st_seen) begin
            st_run++;
            first_st_addr = int'(daddr);
            first_st_data = int'(dwdata);
        end else if (st_run > 0 && !st_seen) begin
            st_seen = 1;
            first_st_len = st_run;
        end
        prev_iread = iread;
        ig = rnd_mode ? ($urandom_range(99) < grant_pct) : 1'b1;
        if (rnd_mode) dg = $urandom_range(99) < grant_pct;
        else dg = (dread || dwrite) && dstall >= dwait;
        if (!rnd_mode && (dread || dwrite)) dstall = dg ? 0 : dstall + 1;
        iready = ig;
        idata  = iread ? imem[iaddr] : 16'($urandom);
        if (iread && ig) iss(imem[m_pc]);
        else if (iread) cur_waits++;
        dready = dg;
        ddata  = dread ? dmem[daddr] : 16'($urandom);
        if ((dread || dwrite) && !dg) cur_waits++;
        if (dwrite && dg) dmem[daddr] = dwdata;
    endtask

    task automatic do_reset(input int cycles);
        reset  = 1'b1;
        iready = 1'b0;
        dready = 1'b0;
        repeat (cycles) @(posedge clock);
        #1 reset = 1'b0;
        m_pc = '0;
        for (int i = 0; i < 8; i++) m_r[i] = '0;
        have_cur   = 0;
        prev_iread = 0;
        exp_kind   = 0;
        cyc        = 0;
        fetches    = 0;
        dstall     = 0;
        fseq.delete();
        fstart.delete();
        for (int i = 0; i < 65536; i++) m_dmem[i] = dmem[i];
    endtask

    initial begin
        int budget;
        logic [15:0] w;
        for (int i = 0; i < 65536; i++) begin
            imem[i] = '0;
            dmem[i] = '0;
        end
        imem[0]     = enc(4, 5, 0, 1);
        imem[1]     = enc(4, -3, 0, 2);
        imem[2]     = enc(0, 2 << 4, 1, 3);
        imem[3]     = enc(6, 4, 0, 1);
        imem[4]     = enc(5, 4, 0, 4);
        imem[5]     = enc(6, 5, 0, 4);
        imem[6]     = enc(4, 1, 0, 5);
        imem[7]     = enc(7, 3, 0, 0);
        imem[8]     = enc(7, 3, 0, 5);
        imem[9]     = enc(7, 2, 0, 0);
        imem[10]    = enc(7, -2, 0, 0);
        imem[11]    = enc(7, -14, 0, 7);
        imem[12]    = enc(6, 6, 0, 7);
        imem[65533] = enc(4, 1, 7, 7);
        imem[65534] = enc(4, 1, 7, 7);
        imem[65535] = enc(4, 1, 7, 7);
        rnd_mode = 0;
        dwait    = 3;
        st_run   = 0;
        st_seen  = 0;

        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_iread", iread, 0);
        chk("rst_dread", dread, 0);
        chk("rst_dwrite", dwrite, 0);
        chk("rst_iaddr", iaddr, 0);
        chk("rst_daddr", daddr, 0);
        chk("rst_dwdata", dwdata, 0);
        chk("rst_alu_out", alu_out, 0);
        chk("rst_state", state_out, 0);

        do_reset(1);
        repeat (200) begin
            tick();
            if (cyc == 13) begin
                chk("wb3_state", state_out, 5);
                chk("wb3_alu_out", alu_out, 2);
            end
        end
        for (int i = 0; i < 17; i++) chk("fetch_seq", fseq.size() > i ? fseq[i] : -1, exp_seq[i]);
        chk("ldur_latency", fstart.size() > 5 ? fstart[5] - fstart[4] : -1, 8);
        chk("stur_len", first_st_len, 4);
        chk("stur_addr", first_st_addr, 4);
        chk("stur_data", first_st_data, 5);
        chk("mem4", dmem[4], 5);
        chk("mem5", dmem[5], 5);
        chk("mem6", dmem[6], 3);

        dwait = 1000000;
        do_reset(2);
        budget = 0;
        while (!dwrite && budget < 100) begin
            tick();
            budget++;
        end
        chk("store_reached", dwrite, 1);
        #2 reset = 1'b1;
        #1;
        chk("abort_dwrite", dwrite, 0);
        chk("abort_iread", iread, 0);
        chk("abort_state", state_out, 0);
        chk("abort_alu_out", alu_out, 0);
        chk("abort_daddr", daddr, 0);
        chk("abort_dwdata", dwdata, 0);
        chk("abort_iaddr", iaddr, 0);
        dwait = 2;
        do_reset(1);
        tick();
        chk("idle_state", state_out, 0);
        chk("idle_iread", iread, 0);
        tick();
        chk("post_idle_iread", iread, 1);
        chk("post_idle_iaddr", iaddr, 0);
        repeat (150) tick();

        rnd_mode = 1;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 65536; i++) begin
                w = 16'($urandom);
                if (w[15:13] == 3'd7 && w[12:6] == 7'd0) w[6] = 1'b1;
                imem[i] = w;
                dmem[i] = 16'($urandom);
            end
            grant_pct = 30 + 14 * r;
            do_reset(2);
            repeat (2500) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
